// File: rtl/mib_pkg.sv
// Shared definitions for the MIB bus master.
// Contents:
//   mib_state_e - transaction FSM state encoding
//   PH_W        - width of the per-state phase counter
//   mib_na()    - number of address phases for a given address/bus width
//   mib_nd()    - number of data phases for a given data/bus width
package mib_pkg;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_ADDR  = 3'd1,
    S_WDATA = 3'd2,
    S_WACK  = 3'd3,
    S_TURN  = 3'd4,
    S_RDATA = 3'd5,
    S_GAP   = 3'd6,
    S_DONE  = 3'd7
  } mib_state_e;

  localparam int unsigned PH_W = 8;

  // Address words needed to carry addr_bits; the top word may be partial.
  function automatic int unsigned mib_na(input int unsigned addr_bits,
                                         input int unsigned mib_bits);
    return (addr_bits + mib_bits - 1) / mib_bits;
  endfunction

  // Data words per transfer; data_bits is an exact multiple of mib_bits.
  function automatic int unsigned mib_nd(input int unsigned data_bits,
                                         input int unsigned mib_bits);
    return data_bits / mib_bits;
  endfunction

endpackage

// File: rtl/mib_bus_master_if.sv
// Command-side and MIB-side signal bundle of the MIB bus master.
// Signals keep the block's port names (i_* into the master, o_* out of it).
// Modports:
//   master - view used by mib_bus_master
//   slave  - view of the environment (command issuer plus MIB slave)
interface mib_bus_master_if #(
  parameter int unsigned P_ADDR_BITS = 24,
  parameter int unsigned P_DATA_BITS = 32,
  parameter int unsigned P_MIB_BITS  = 16
) ();

  logic                   i_cmd_sel;
  logic                   i_cmd_rd_wr_n;
  logic [P_ADDR_BITS-1:0] i_cmd_byte_addr;
  logic [P_DATA_BITS-1:0] i_cmd_wdata;
  logic                   o_cmd_ack;
  logic [P_DATA_BITS-1:0] o_cmd_rdata;
  logic                   o_cmd_mib_timeout;
  logic                   o_cmd_drop;
  logic                   o_busy;

  logic [P_MIB_BITS-1:0]  i_mib_ad;
  logic                   i_mib_slave_ack;
  logic                   o_mib_start;
  logic                   o_mib_rd_wr_n;
  logic                   o_mib_ad_high_z;
  logic [P_MIB_BITS-1:0]  o_mib_ad;

  modport master (
    input  i_cmd_sel, i_cmd_rd_wr_n, i_cmd_byte_addr, i_cmd_wdata,
    input  i_mib_ad, i_mib_slave_ack,
    output o_cmd_ack, o_cmd_rdata, o_cmd_mib_timeout, o_cmd_drop, o_busy,
    output o_mib_start, o_mib_rd_wr_n, o_mib_ad_high_z, o_mib_ad
  );

  modport slave (
    output i_cmd_sel, i_cmd_rd_wr_n, i_cmd_byte_addr, i_cmd_wdata,
    output i_mib_ad, i_mib_slave_ack,
    input  o_cmd_ack, o_cmd_rdata, o_cmd_mib_timeout, o_cmd_drop, o_busy,
    input  o_mib_start, o_mib_rd_wr_n, o_mib_ad_high_z, o_mib_ad
  );

endinterface

// File: rtl/mib_ack_timer.sv
// Slave-ack watchdog for the MIB bus master.
// Ports:
//   i_clk, i_srst - clock, synchronous active-high reset
//   i_clear       - zero the count (has priority over i_enable)
//   i_enable      - count one clock of waiting
//   o_expired     - high on the P_CLKS-th consecutive enabled clock
module mib_ack_timer #(
  parameter int unsigned P_CLKS = 32
) (
  input  logic i_clk,
  input  logic i_srst,
  input  logic i_clear,
  input  logic i_enable,
  output logic o_expired
);

  localparam int unsigned CNT_W = (P_CLKS > 1) ? $clog2(P_CLKS) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(P_CLKS - 1);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  // Counts clocks already waited; the clock seen with CNT_LAST is the last one.
  assign o_expired = i_enable && (cnt_q == CNT_LAST);

  always_comb begin
    cnt_d = cnt_q;
    if (i_clear) begin
      cnt_d = '0;
    end else if (i_enable && !o_expired) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_srst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/mib_bus_master.sv
// MIB bus master: turns a one-clock command strobe into a multiplexed
// address/data MIB transaction with ack timeout and optional retries.
// Ports:
//   i_sysclk - sole clock
//   i_srst   - synchronous active-high reset (aborts any transaction silently)
//   bus      - mib_bus_master_if.master: command side (sel, direction, address,
//              write data, ack, read data, timeout, drop, busy) and MIB side
//              (AD in/out, slave ack, start, direction, AD release)
// All outputs are registered and computed from the next state, so they are
// aligned with the state the FSM is in during that clock.
module mib_bus_master
  import mib_pkg::*;
#(
  parameter int unsigned P_ADDR_BITS            = 24,
  parameter int unsigned P_DATA_BITS            = 32,
  parameter int unsigned P_MIB_BITS             = 16,
  parameter int unsigned P_MIB_ACK_TIMEOUT_CLKS = 32,
  parameter int unsigned P_RETRIES              = 0,
  parameter int unsigned P_TURNAROUND_CLKS      = 1
) (
  input  logic             i_sysclk,
  input  logic             i_srst,
  mib_bus_master_if.master bus
);

  localparam int unsigned NA        = mib_na(P_ADDR_BITS, P_MIB_BITS);
  localparam int unsigned ND        = mib_nd(P_DATA_BITS, P_MIB_BITS);
  localparam int unsigned AEXT_BITS = NA * P_MIB_BITS;
  localparam int unsigned RETRY_W   = (P_RETRIES > 0) ? $clog2(P_RETRIES + 1) : 1;

  localparam logic [PH_W-1:0] PH_ADDR_LAST = PH_W'(NA - 1);
  localparam logic [PH_W-1:0] PH_DATA_LAST = PH_W'(ND - 1);
  localparam logic [PH_W-1:0] PH_TURN_LAST = PH_W'(P_TURNAROUND_CLKS - 1);
  localparam logic [PH_W-1:0] PH_GAP_LAST  = PH_W'(1);

  mib_state_e             state_q, state_d;
  logic [PH_W-1:0]        ph_q, ph_d;
  logic [RETRY_W-1:0]     retry_q, retry_d;

  logic [P_ADDR_BITS-1:0] addr_q, addr_d;
  logic [P_DATA_BITS-1:0] wdata_q, wdata_d;
  logic                   dir_q, dir_d;
  logic [P_DATA_BITS-1:0] shift_q, shift_d;

  logic                   start_q, start_d;
  logic                   rdwrn_q, rdwrn_d;
  logic                   hz_q, hz_d;
  logic [P_MIB_BITS-1:0]  ad_q, ad_d;
  logic                   ack_q, ack_d;
  logic [P_DATA_BITS-1:0] rdata_q, rdata_d;
  logic                   tmo_q, tmo_d;
  logic                   drop_q, drop_d;
  logic                   busy_q, busy_d;

  logic                   tmr_en;
  logic                   tmr_clear;
  logic                   tmr_expired;

  // Word ph of a zero-extended address, most-significant word first.
  function automatic logic [P_MIB_BITS-1:0] addr_word(input logic [AEXT_BITS-1:0] v,
                                                      input logic [PH_W-1:0] ph);
    logic [AEXT_BITS-1:0] s;
    s = v >> (P_MIB_BITS * (NA - 1 - 32'(ph)));
    return s[P_MIB_BITS-1:0];
  endfunction

  function automatic logic [P_MIB_BITS-1:0] data_word(input logic [P_DATA_BITS-1:0] v,
                                                      input logic [PH_W-1:0] ph);
    logic [P_DATA_BITS-1:0] s;
    s = v >> (P_MIB_BITS * (ND - 1 - 32'(ph)));
    return s[P_MIB_BITS-1:0];
  endfunction

  // The watchdog runs only while waiting on the slave; any ack restarts it.
  assign tmr_en    = (state_q == S_WACK) || (state_q == S_RDATA);
  assign tmr_clear = !tmr_en || bus.i_mib_slave_ack;

  mib_ack_timer #(
    .P_CLKS(P_MIB_ACK_TIMEOUT_CLKS)
  ) u_ack_timer (
    .i_clk    (i_sysclk),
    .i_srst   (i_srst),
    .i_clear  (tmr_clear),
    .i_enable (tmr_en),
    .o_expired(tmr_expired)
  );

  always_comb begin
    state_d = state_q;
    ph_d    = ph_q;
    retry_d = retry_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    dir_d   = dir_q;
    shift_d = shift_q;
    rdata_d = rdata_q;
    ack_d   = 1'b0;
    tmo_d   = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (bus.i_cmd_sel) begin
          addr_d  = bus.i_cmd_byte_addr;
          wdata_d = bus.i_cmd_wdata;
          dir_d   = bus.i_cmd_rd_wr_n;
          retry_d = RETRY_W'(P_RETRIES);
          shift_d = '0;
          ph_d    = '0;
          state_d = S_ADDR;
        end
      end
      S_ADDR: begin
        if (ph_q == PH_ADDR_LAST) begin
          ph_d    = '0;
          state_d = dir_q ? S_TURN : S_WDATA;
        end else begin
          ph_d = ph_q + PH_W'(1);
        end
      end
      S_WDATA: begin
        if (ph_q == PH_DATA_LAST) begin
          ph_d    = '0;
          state_d = S_WACK;
        end else begin
          ph_d = ph_q + PH_W'(1);
        end
      end
      S_TURN: begin
        if (ph_q == PH_TURN_LAST) begin
          ph_d    = '0;
          state_d = S_RDATA;
        end else begin
          ph_d = ph_q + PH_W'(1);
        end
      end
      S_WACK, S_RDATA: begin
        // An ack on the expiry clock still counts as an ack.
        if (bus.i_mib_slave_ack) begin
          if (state_q == S_WACK) begin
            ack_d   = 1'b1;
            state_d = S_DONE;
          end else begin
            shift_d = (shift_q << P_MIB_BITS) | P_DATA_BITS'(bus.i_mib_ad);
            if (ph_q == PH_DATA_LAST) begin
              rdata_d = shift_d;
              ack_d   = 1'b1;
              ph_d    = '0;
              state_d = S_DONE;
            end else begin
              ph_d = ph_q + PH_W'(1);
            end
          end
        end else if (tmr_expired) begin
          ph_d = '0;
          if (retry_q != '0) begin
            retry_d = retry_q - RETRY_W'(1);
            state_d = S_GAP;
          end else begin
            // Final failure: the DONE clock carries the timeout pulse instead of an ack.
            tmo_d   = 1'b1;
            state_d = S_DONE;
          end
        end
      end
      S_GAP: begin
        if (ph_q == PH_GAP_LAST) begin
          ph_d    = '0;
          shift_d = '0;
          state_d = S_ADDR;
        end else begin
          ph_d = ph_q + PH_W'(1);
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_comb begin
    start_d = (state_d == S_ADDR) && (ph_d == '0);
    hz_d    = !((state_d == S_ADDR) || (state_d == S_WDATA));
    rdwrn_d = (state_d == S_IDLE) ? 1'b1 : dir_d;
    busy_d  = (state_d != S_IDLE);
    drop_d  = bus.i_cmd_sel && (state_q != S_IDLE);
    ad_d    = '0;
    if (state_d == S_ADDR) begin
      ad_d = addr_word(AEXT_BITS'(addr_d), ph_d);
    end else if (state_d == S_WDATA) begin
      ad_d = data_word(wdata_d, ph_d);
    end
  end

  always_ff @(posedge i_sysclk) begin
    if (i_srst) begin
      state_q <= S_IDLE;
      ph_q    <= '0;
      retry_q <= '0;
      start_q <= 1'b0;
      rdwrn_q <= 1'b1;
      hz_q    <= 1'b1;
      ad_q    <= '0;
      ack_q   <= 1'b0;
      rdata_q <= '0;
      tmo_q   <= 1'b0;
      drop_q  <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      ph_q    <= ph_d;
      retry_q <= retry_d;
      start_q <= start_d;
      rdwrn_q <= rdwrn_d;
      hz_q    <= hz_d;
      ad_q    <= ad_d;
      ack_q   <= ack_d;
      rdata_q <= rdata_d;
      tmo_q   <= tmo_d;
      drop_q  <= drop_d;
      busy_q  <= busy_d;
    end
  end

  // Captured command and read shifter are only consumed outside IDLE.
  always_ff @(posedge i_sysclk) begin
    addr_q  <= addr_d;
    wdata_q <= wdata_d;
    dir_q   <= dir_d;
    shift_q <= shift_d;
  end

  assign bus.o_mib_start       = start_q;
  assign bus.o_mib_rd_wr_n     = rdwrn_q;
  assign bus.o_mib_ad_high_z   = hz_q;
  assign bus.o_mib_ad          = ad_q;
  assign bus.o_cmd_ack         = ack_q;
  assign bus.o_cmd_rdata       = rdata_q;
  assign bus.o_cmd_mib_timeout = tmo_q;
  assign bus.o_cmd_drop        = drop_q;
  assign bus.o_busy            = busy_q;

endmodule

// File: doc/mib_bus_master.md
MIB_BUS_MASTER -- requirements
Module: mib_bus_master

Interface
REQ-001 SHALL have parameter P_ADDR_BITS, default 24, which sets the command byte address width.
REQ-002 SHALL have parameter P_DATA_BITS, default 32, which sets the command data width; it must be a multiple of P_MIB_BITS.
REQ-003 SHALL have parameter P_MIB_BITS, default 16, which sets the MIB AD bus width.
REQ-004 SHALL have parameter P_MIB_ACK_TIMEOUT_CLKS, default 32, which sets the clocks to wait for a slave ack.
REQ-005 SHALL have parameter P_RETRIES, default 0, which sets the number of automatic re-issues after a timeout.
REQ-006 SHALL have parameter P_TURNAROUND_CLKS, default 1, which sets the high-Z clocks between read address and read data (minimum 1).
REQ-007 SHALL have one clock and a synchronous, active-high reset: i_sysclk  in  1  sole clock; i_srst  in  1  synchronous active-high reset.
REQ-008 SHALL have the command-side ports:
- i_cmd_sel  in  1  one-clock request strobe.
- i_cmd_rd_wr_n  in  1  1=read 0=write.
- i_cmd_byte_addr  in  P_ADDR_BITS  target address.
- i_cmd_wdata  in  P_DATA_BITS  write data.
- o_cmd_ack  out  1  one-clock completion pulse.
- o_cmd_rdata  out  P_DATA_BITS  read data, valid with o_cmd_ack.
- o_cmd_mib_timeout  out  1  one-clock final-failure pulse.
- o_cmd_drop  out  1  one-clock pulse when i_cmd_sel arrives while busy.
- o_busy  out  1  transaction in flight.
REQ-009 SHALL have the MIB-side ports:
- i_mib_ad  in  P_MIB_BITS  slave read data.
- i_mib_slave_ack  in  1  slave ack.
- o_mib_start  out  1  first address phase marker.
- o_mib_rd_wr_n  out  1  transaction direction.
- o_mib_ad_high_z  out  1  1=release the AD bus.
- o_mib_ad  out  P_MIB_BITS  master address/data.

Function
REQ-010 SHALL define NA=ceil(P_ADDR_BITS/P_MIB_BITS) address phases and ND=P_DATA_BITS/P_MIB_BITS data phases; a partial top address word SHALL be zero-extended.
REQ-011 SHALL use FSM states IDLE, ADDR, WDATA, WACK, TURN, RDATA, GAP, DONE.
REQ-012 SHALL capture address, data and direction in IDLE when i_cmd_sel=1 and enter ADDR on the next clock (cycle 1).
REQ-013 In ADDR, SHALL drive address words most-significant first, one per clock, for NA clocks; o_mib_start=1 only in the first ADDR clock; o_mib_ad_high_z=0; o_mib_rd_wr_n holds the captured direction for the whole transaction.
REQ-014 On write, after ADDR the block SHALL enter WDATA and drive ND data words MS-first on consecutive clocks, then enter WACK with o_mib_ad_high_z=1.
REQ-015 In WACK, i_mib_slave_ack=1 SHALL move to DONE; o_cmd_ack SHALL pulse the clock after the ack is sampled.
REQ-016 On read, after ADDR the block SHALL hold TURN for P_TURNAROUND_CLKS with high_z=1, then enter RDATA.
REQ-017 In RDATA, each clock with i_mib_slave_ack=1 SHALL shift i_mib_ad into the read word MS-first; after the ND-th word the block SHALL enter DONE and assert o_cmd_rdata with o_cmd_ack.
REQ-018 The timeout counter SHALL clear on entry to WACK/RDATA and on every sampled ack; reaching P_MIB_ACK_TIMEOUT_CLKS without an ack is a timeout.
REQ-019 On a timeout with retries remaining, the block SHALL enter GAP for 2 clocks with high_z=1, decrement the retry count, and restart ADDR with the same captured command; partial read words SHALL be discarded.
REQ-020 On a timeout with no retries left, the block SHALL pulse o_cmd_mib_timeout, SHALL NOT pulse o_cmd_ack, SHALL leave o_cmd_rdata unchanged, and SHALL return to IDLE.
REQ-021 An ack while in ADDR/WDATA/TURN/GAP SHALL be ignored.
REQ-022 i_cmd_sel while o_busy=1 SHALL be ignored and pulse o_cmd_drop; i_cmd_sel in the DONE clock counts as busy.
REQ-023 An ack and a timeout on the same clock SHALL resolve as the ack.
REQ-024 o_busy SHALL be 1 from cycle 1 through DONE or the final timeout clock; outputs SHALL be registered.

Reset
REQ-025 i_srst SHALL force IDLE, o_mib_start=0, o_mib_rd_wr_n=1, o_mib_ad_high_z=1, o_mib_ad=0, o_cmd_ack=0, o_cmd_rdata=0, o_cmd_mib_timeout=0, o_cmd_drop=0, o_busy=0, and clear the counters.
REQ-026 A reset mid-transaction SHALL abort it silently, with no ack and no timeout pulse.

Structure
REQ-027 Package mib_pkg SHALL hold the FSM state enum and the NA/ND phase-count functions.
REQ-028 The timeout counter SHALL be a sub-module, mib_ack_timer (clear, enable, expired).

Verification
REQ-029 Default parameters, write 0x000004 <- 0x01010202, slave acks 3 clocks after WACK entry: AD shows 0x0000, 0x0004, 0x0101, 0x0202; o_mib_start only on the first word; one o_cmd_ack.
REQ-030 Read 0x000008, slave returns 0xDEAD then 0xBEEF: the TURN clock has high_z=1; o_cmd_rdata=0xDEADBEEF with o_cmd_ack.
REQ-031 P_RETRIES=0, no slave ack: o_cmd_mib_timeout pulses exactly 32 clocks after WACK entry; no o_cmd_ack; o_busy drops.
REQ-032 P_RETRIES=2, slave acks only on the third attempt: two GAP sequences, then o_cmd_ack; rdata matches the third attempt.
REQ-033 Second i_cmd_sel during a read: o_cmd_drop pulses once and the first transaction completes unaffected.
REQ-034 i_srst asserted in RDATA after the first word: all outputs reach reset values next clock; no ack; a subsequent read completes normally.
